// File: rtl/axi4_burst_mgr_if.sv
// AXI4 bus bundle shared by the burst manager and its subordinate.
// The manager drives the request channels; the subordinate drives the responses.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi4_burst_mgr.sv
// AXI4 INCR burst manager: splits word-aligned stream commands into bursts limited
// by MAX_BURST_LEN and 4 kB pages; independent read and write engines.
module axi4_burst_mgr #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned MAX_BURST_LEN  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_req_i,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [LEN_WIDTH-1:0]      wr_beats_i,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  output logic                      wr_busy_o,
  output logic                      wr_done_o,
  output logic [1:0]                wr_err_o,
  input  logic                      rd_req_i,
  input  logic [AXI_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [LEN_WIDTH-1:0]      rd_beats_i,
  output logic [AXI_DATA_WIDTH-1:0] rd_data_o,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic                      rd_busy_o,
  output logic                      rd_done_o,
  output logic [1:0]                rd_err_o,
  AXI_BUS.Master                    axi_mgr_if
);

  localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFFS  = $clog2(BYTES);
  localparam int unsigned BW    = $clog2(MAX_BURST_LEN + 1);
  localparam int unsigned CW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rstate_e;

  // Beats left in the current 4 kB page, clipped by MAX_BURST_LEN and the remaining count.
  function automatic logic [BW-1:0] calc_burst(input logic [11-OFFS:0]    pg_idx,
                                               input logic [LEN_WIDTH-1:0] rem);
    logic [CW-1:0] lim;
    logic [CW-1:0] rem_c;
    lim   = CW'(4096 >> OFFS) - CW'(pg_idx);
    rem_c = CW'(rem);
    if (lim > CW'(MAX_BURST_LEN)) lim = CW'(MAX_BURST_LEN);
    if (rem_c < lim) lim = rem_c;
    return BW'(lim);
  endfunction

  // ---------------- write engine ----------------
  wstate_e                   w_state_q, w_state_d;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [LEN_WIDTH-1:0]      w_rem_q, w_rem_d;
  logic [7:0]                w_len_q, w_len_d;
  logic [BW-1:0]             w_cnt_q, w_cnt_d;
  logic [1:0]                w_err_q, w_err_d;
  logic                      w_done_q, w_done_d;
  logic                      aw_valid_q;
  logic [BW-1:0]             w_burst, w_burst_new;
  logic                      w_fire;

  assign w_burst = BW'(w_len_q) + BW'(1);
  assign w_fire  = (w_state_q == W_W) & wr_valid_i & axi_mgr_if.w_ready;

  always_comb begin
    w_state_d   = w_state_q;
    w_addr_d    = w_addr_q;
    w_rem_d     = w_rem_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    w_err_d     = w_err_q;
    w_done_d    = 1'b0;
    w_burst_new = '0;
    unique case (w_state_q)
      W_IDLE: if (wr_req_i) begin
        w_addr_d = {wr_addr_i[AXI_ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
        w_rem_d  = wr_beats_i;
        w_err_d  = '0;
        if (wr_beats_i == '0) w_done_d = 1'b1;
        else                  w_state_d = W_AW;
      end
      W_AW: if (axi_mgr_if.aw_ready) w_state_d = W_W;
      W_W: if (w_fire) begin
        w_cnt_d = w_cnt_q - BW'(1);
        if (w_cnt_q == BW'(1)) w_state_d = W_B;
      end
      W_B: if (axi_mgr_if.b_valid) begin
        if ((axi_mgr_if.b_resp != 2'b00) && (w_err_q == 2'b00)) w_err_d = axi_mgr_if.b_resp;
        w_rem_d  = w_rem_q - LEN_WIDTH'(w_burst);
        w_addr_d = w_addr_q + (AXI_ADDR_WIDTH'(w_burst) << OFFS);
        if (w_rem_d == '0) begin
          w_state_d = W_IDLE;
          w_done_d  = 1'b1;
        end else begin
          w_state_d = W_AW;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    // Burst is sized from the already-advanced address/remaining on every AW entry.
    if ((w_state_d == W_AW) && (w_state_q != W_AW)) begin
      w_burst_new = calc_burst(w_addr_d[11:OFFS], w_rem_d);
      w_len_d     = 8'(w_burst_new - BW'(1));
      w_cnt_d     = w_burst_new;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q  <= W_IDLE;
      w_addr_q   <= '0;
      w_rem_q    <= '0;
      w_len_q    <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= '0;
      w_done_q   <= 1'b0;
      aw_valid_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      w_addr_q   <= w_addr_d;
      w_rem_q    <= w_rem_d;
      w_len_q    <= w_len_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      w_done_q   <= w_done_d;
      aw_valid_q <= (w_state_d == W_AW);
    end
  end

  assign wr_busy_o = (w_state_q != W_IDLE);
  assign wr_done_o = w_done_q;
  assign wr_err_o  = w_err_q;
  assign wr_ready_o = (w_state_q == W_W) & axi_mgr_if.w_ready;

  assign axi_mgr_if.aw_id     = '0;
  assign axi_mgr_if.aw_addr   = w_addr_q;
  assign axi_mgr_if.aw_len    = w_len_q;
  assign axi_mgr_if.aw_size   = 3'(OFFS);
  assign axi_mgr_if.aw_burst  = 2'b01;
  assign axi_mgr_if.aw_lock   = 1'b0;
  assign axi_mgr_if.aw_cache  = '0;
  assign axi_mgr_if.aw_prot   = '0;
  assign axi_mgr_if.aw_qos    = '0;
  assign axi_mgr_if.aw_region = '0;
  assign axi_mgr_if.aw_atop   = '0;
  assign axi_mgr_if.aw_user   = '0;
  assign axi_mgr_if.aw_valid  = aw_valid_q;
  assign axi_mgr_if.w_data    = wr_data_i;
  assign axi_mgr_if.w_strb    = '1;
  assign axi_mgr_if.w_last    = (w_state_q == W_W) && (w_cnt_q == BW'(1));
  assign axi_mgr_if.w_user    = '0;
  assign axi_mgr_if.w_valid   = (w_state_q == W_W) & wr_valid_i;
  assign axi_mgr_if.b_ready   = (w_state_q == W_B);

  // ---------------- read engine ----------------
  rstate_e                   r_state_q, r_state_d;
  logic [AXI_ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [LEN_WIDTH-1:0]      r_rem_q, r_rem_d;
  logic [7:0]                r_len_q, r_len_d;
  logic [BW-1:0]             r_cnt_q, r_cnt_d;
  logic [1:0]                r_err_q, r_err_d;
  logic                      r_done_q, r_done_d;
  logic                      ar_valid_q;
  logic [BW-1:0]             r_burst, r_burst_new;
  logic                      r_fire;

  assign r_burst = BW'(r_len_q) + BW'(1);
  assign r_fire  = (r_state_q == R_R) & axi_mgr_if.r_valid & rd_ready_i;

  always_comb begin
    r_state_d   = r_state_q;
    r_addr_d    = r_addr_q;
    r_rem_d     = r_rem_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    r_err_d     = r_err_q;
    r_done_d    = 1'b0;
    r_burst_new = '0;
    unique case (r_state_q)
      R_IDLE: if (rd_req_i) begin
        r_addr_d = {rd_addr_i[AXI_ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
        r_rem_d  = rd_beats_i;
        r_err_d  = '0;
        if (rd_beats_i == '0) r_done_d = 1'b1;
        else                  r_state_d = R_AR;
      end
      R_AR: if (axi_mgr_if.ar_ready) r_state_d = R_R;
      R_R: if (r_fire) begin
        r_cnt_d = r_cnt_q - BW'(1);
        // Our own beat counter ends the burst; a misplaced RLAST is only reported.
        if (r_err_q == 2'b00) begin
          if (axi_mgr_if.r_resp != 2'b00)                         r_err_d = axi_mgr_if.r_resp;
          else if (axi_mgr_if.r_last != (r_cnt_q == BW'(1)))      r_err_d = 2'b10;
        end
        if (r_cnt_q == BW'(1)) begin
          r_rem_d  = r_rem_q - LEN_WIDTH'(r_burst);
          r_addr_d = r_addr_q + (AXI_ADDR_WIDTH'(r_burst) << OFFS);
          if (r_rem_d == '0) begin
            r_state_d = R_IDLE;
            r_done_d  = 1'b1;
          end else begin
            r_state_d = R_AR;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if ((r_state_d == R_AR) && (r_state_q != R_AR)) begin
      r_burst_new = calc_burst(r_addr_d[11:OFFS], r_rem_d);
      r_len_d     = 8'(r_burst_new - BW'(1));
      r_cnt_d     = r_burst_new;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q  <= R_IDLE;
      r_addr_q   <= '0;
      r_rem_q    <= '0;
      r_len_q    <= '0;
      r_cnt_q    <= '0;
      r_err_q    <= '0;
      r_done_q   <= 1'b0;
      ar_valid_q <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_addr_q   <= r_addr_d;
      r_rem_q    <= r_rem_d;
      r_len_q    <= r_len_d;
      r_cnt_q    <= r_cnt_d;
      r_err_q    <= r_err_d;
      r_done_q   <= r_done_d;
      ar_valid_q <= (r_state_d == R_AR);
    end
  end

  assign rd_busy_o  = (r_state_q != R_IDLE);
  assign rd_done_o  = r_done_q;
  assign rd_err_o   = r_err_q;
  assign rd_valid_o = (r_state_q == R_R) & axi_mgr_if.r_valid;
  assign rd_data_o  = (r_state_q == R_R) ? axi_mgr_if.r_data : '0;

  assign axi_mgr_if.ar_id     = '0;
  assign axi_mgr_if.ar_addr   = r_addr_q;
  assign axi_mgr_if.ar_len    = r_len_q;
  assign axi_mgr_if.ar_size   = 3'(OFFS);
  assign axi_mgr_if.ar_burst  = 2'b01;
  assign axi_mgr_if.ar_lock   = 1'b0;
  assign axi_mgr_if.ar_cache  = '0;
  assign axi_mgr_if.ar_prot   = '0;
  assign axi_mgr_if.ar_qos    = '0;
  assign axi_mgr_if.ar_region = '0;
  assign axi_mgr_if.ar_user   = '0;
  assign axi_mgr_if.ar_valid  = ar_valid_q;
  assign axi_mgr_if.r_ready   = (r_state_q == R_R) & rd_ready_i;

  logic unused_ok;
  assign unused_ok = ^{wr_addr_i[OFFS-1:0], rd_addr_i[OFFS-1:0],
                       axi_mgr_if.b_id, axi_mgr_if.b_user,
                       axi_mgr_if.r_id, axi_mgr_if.r_user};

endmodule
